// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
package bram_arb_pkg;

   localparam int unsigned LOCK_CNT_W = 16;
   // Widest supported requester set; rr_pick works on this width.
   localparam int unsigned MAX_REQ    = 8;
   localparam int unsigned MAX_PTR_W  = 3;

   typedef enum logic [0:0] {
      IDLE,
      LOCKED
   } arb_state_e;

   // One-hot winner: first set bit of req scanning upward from ptr, modulo n.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0]   req,
      input logic [MAX_PTR_W-1:0] ptr,
      input int unsigned          n
   );
      logic [MAX_REQ-1:0] oh;
      logic [3:0]         idx;
      oh = '0;
      for (int k = 0; k < int'(MAX_REQ); k++) begin
         idx = 4'(ptr) + 4'(k);
         if (idx >= 4'(n)) begin
            idx = idx - 4'(n);
         end
         if ((k < int'(n)) && (oh == '0) && req[idx[2:0]]) begin
            oh[idx[2:0]] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Read-tag delay line: carries the one-hot requester tag of each read for
// DEPTH cycles so it lines up with the BRAM output. Synchronous clear.
module bram_arb_tag_pipe
   import bram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_tag,
   output logic [WIDTH-1:0] o_tag
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   // Shift tags one stage per cycle; reset drops every in-flight read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with
// optional locked bursts and tagged read return.
// Optional conflict statistics counter enabled by macro BRAM_ARB_STATS_EN.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned ADDR_WIDTH   = 17,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned MAX_LOCK     = 64
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ-1:0]            i_lock,
   input  logic [NUM_REQ-1:0]            i_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [NUM_REQ-1:0]            o_rvalid,
   output logic [DATA_WIDTH-1:0]         o_rdata,
   output logic [ADDR_WIDTH-1:0]         o_mem_addr,
   output logic [DATA_WIDTH-1:0]         o_mem_din,
   output logic                          o_mem_we,
   input  logic [DATA_WIDTH-1:0]         i_mem_dout,
   output logic                          o_locked,
   output logic [31:0]                   o_conflict_cnt
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   arb_state_e              r_state, w_state_d;
   logic [PTR_W-1:0]        r_rr_ptr, w_rr_ptr_d;
   logic [PTR_W-1:0]        r_owner, w_owner_d;
   logic [LOCK_CNT_W-1:0]   r_lock_cnt, w_lock_cnt_d;
   logic [ADDR_WIDTH-1:0]   r_addr_shadow;

   logic [MAX_REQ-1:0]      w_req_ext;
   logic [MAX_REQ-1:0]      w_pick;
   logic [NUM_REQ-1:0]      w_gnt;
   logic [PTR_W-1:0]        w_gnt_idx;
   logic                    w_gnt_any;
   logic [NUM_REQ-1:0]      w_rd_tag;
   logic [LOCK_CNT_W-1:0]   w_cnt_inc;
   logic                    w_cnt_hit;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin candidate, computed from the requests and the pointer.
   always_comb begin
      w_req_ext                = '0;
      w_req_ext[NUM_REQ-1:0]   = i_req;
      w_pick                   = rr_pick(w_req_ext, MAX_PTR_W'(r_rr_ptr), NUM_REQ);
   end

   // FSM state register plus the datapath registers it owns.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_rr_ptr      <= '0;
         r_owner       <= '0;
         r_lock_cnt    <= '0;
         r_addr_shadow <= '0;
      end else begin
         r_state       <= w_state_d;
         r_rr_ptr      <= w_rr_ptr_d;
         r_owner       <= w_owner_d;
         r_lock_cnt    <= w_lock_cnt_d;
         r_addr_shadow <= o_mem_addr;
      end
   end

   // Next-state logic: lock entry from IDLE, release conditions in LOCKED.
   always_comb begin
      w_state_d    = r_state;
      w_rr_ptr_d   = r_rr_ptr;
      w_owner_d    = r_owner;
      w_lock_cnt_d = r_lock_cnt;
      w_cnt_inc    = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + 1'b1;
      // Release on the grant that brings the burst length up to MAX_LOCK.
      w_cnt_hit    = (MAX_LOCK != 0) && (32'(w_cnt_inc) >= MAX_LOCK);
      unique case (r_state)
         IDLE: begin
            if (w_gnt_any) begin
               w_rr_ptr_d = ptr_next(w_gnt_idx);
               // With MAX_LOCK==1 the first grant already uses the whole budget.
               if (i_lock[w_gnt_idx] && (MAX_LOCK != 1)) begin
                  w_state_d    = LOCKED;
                  w_owner_d    = w_gnt_idx;
                  w_lock_cnt_d = LOCK_CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (!i_req[r_owner]) begin
               w_state_d  = IDLE;
               w_rr_ptr_d = ptr_next(r_owner);
            end else begin
               w_lock_cnt_d = w_cnt_inc;
               if (!i_lock[r_owner] || w_cnt_hit) begin
                  w_state_d  = IDLE;
                  w_rr_ptr_d = ptr_next(r_owner);
               end
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   // Output logic: grant, winner decode and BRAM port mux.
   always_comb begin
      w_gnt = '0;
      if (!i_rst) begin
         if (r_state == IDLE) begin
            w_gnt = w_pick[NUM_REQ-1:0];
         end else if (i_req[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
         end
      end
      w_gnt_idx = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (w_gnt[i]) begin
            w_gnt_idx = PTR_W'(i);
         end
      end
      w_gnt_any = |w_gnt;
      if (w_gnt_any) begin
         o_mem_addr = i_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         o_mem_din  = i_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         o_mem_we   = i_we[w_gnt_idx];
      end else begin
         o_mem_addr = r_addr_shadow;
         o_mem_din  = '0;
         o_mem_we   = 1'b0;
      end
      w_rd_tag = (w_gnt_any && !i_we[w_gnt_idx]) ? w_gnt : '0;
      o_gnt    = w_gnt;
      o_locked = (r_state == LOCKED);
   end

   bram_arb_tag_pipe #(
      .DEPTH (READ_LATENCY),
      .WIDTH (NUM_REQ)
   ) u_tag_pipe (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_tag (w_rd_tag),
      .o_tag (o_rvalid)
   );

   assign o_rdata = i_mem_dout;

`ifdef BRAM_ARB_STATS_EN
   logic [31:0] r_conflict_cnt;
   logic        w_multi_req;

   // A conflict is any cycle with two or more requests, granted or not.
   always_comb begin
      w_multi_req = ($countones(i_req) >= 2);
   end

   // Saturating conflict counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_conflict_cnt <= '0;
      end else if (w_multi_req && (r_conflict_cnt != '1)) begin
         r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
   end

   assign o_conflict_cnt = r_conflict_cnt;
`else
   assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter. dut_a: READ_LATENCY=1, MAX_LOCK=4.
// dut_b: READ_LATENCY=3, MAX_LOCK=64. Both share the same request inputs;
// each owns a small behavioural BRAM that reloads known contents on reset.
module tb_bram_port_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned AW = 17;
   localparam int unsigned DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req, lock, we;
   logic [NR*AW-1:0]  addr;
   logic [NR*DW-1:0]  wdata;

   logic [NR-1:0]     a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0]     a_rdata, a_mem_din, a_mem_dout, b_rdata, b_mem_din, b_mem_dout;
   logic [AW-1:0]     a_mem_addr, b_mem_addr;
   logic              a_mem_we, b_mem_we, a_locked, b_locked;
   logic [31:0]       a_cnt, b_cnt;

   logic [DW-1:0]     mem_a [256];
   logic [DW-1:0]     mem_b [256];
   logic [DW-1:0]     b_p0, b_p1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(
      .NUM_REQ (NR), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .READ_LATENCY (1), .MAX_LOCK (4)
   ) dut_a (
      .i_clk (clk), .i_rst (rst), .i_req (req), .i_lock (lock), .i_we (we),
      .i_addr (addr), .i_wdata (wdata), .o_gnt (a_gnt), .o_rvalid (a_rvalid),
      .o_rdata (a_rdata), .o_mem_addr (a_mem_addr), .o_mem_din (a_mem_din),
      .o_mem_we (a_mem_we), .i_mem_dout (a_mem_dout), .o_locked (a_locked),
      .o_conflict_cnt (a_cnt)
   );

   bram_port_arbiter #(
      .NUM_REQ (NR), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .READ_LATENCY (3), .MAX_LOCK (64)
   ) dut_b (
      .i_clk (clk), .i_rst (rst), .i_req (req), .i_lock (lock), .i_we (we),
      .i_addr (addr), .i_wdata (wdata), .o_gnt (b_gnt), .o_rvalid (b_rvalid),
      .o_rdata (b_rdata), .o_mem_addr (b_mem_addr), .o_mem_din (b_mem_din),
      .o_mem_we (b_mem_we), .i_mem_dout (b_mem_dout), .o_locked (b_locked),
      .o_conflict_cnt (b_cnt)
   );

   // BRAM models: contents A500_00xx after reset, latency 1 (a) and 3 (b).
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA500_0000 | 32'(i);
      end else if (a_mem_we) begin
         mem_a[a_mem_addr[7:0]] <= a_mem_din;
      end
      a_mem_dout <= mem_a[a_mem_addr[7:0]];
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= 32'hA500_0000 | 32'(i);
      end else if (b_mem_we) begin
         mem_b[b_mem_addr[7:0]] <= b_mem_din;
      end
      b_p0       <= mem_b[b_mem_addr[7:0]];
      b_p1       <= b_p0;
      b_mem_dout <= b_p1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic reset_all();
      rst   = 1'b1;
      req   = '0;
      lock  = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      settle();
      next_cycle();
      rst = 1'b0;
   endtask

   logic [2:0]  rr_gnt  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [31:0] rr_data [6] = '{32'hA500_0011, 32'hA500_0022, 32'hA500_0033,
                                32'hA500_0011, 32'hA500_0022, 32'hA500_0033};
   logic [2:0]  lk_req  [6] = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
   logic [2:0]  lk_lock [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
   logic [2:0]  lk_gnt  [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
   logic        lk_lkd  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [2:0]  ml_gnt  [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
   logic        ml_lkd  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

`ifdef BRAM_ARB_STATS_EN
   localparam logic [31:0] ExpConflicts = 32'd10;
`else
   localparam logic [31:0] ExpConflicts = 32'd0;
`endif

   initial begin
      logic [2:0] prev;

      // Reset state.
      reset_all();
      settle();
      chk("rst_gnt", 32'(a_gnt), 32'h0);
      chk("rst_rvalid", 32'(a_rvalid), 32'h0);
      chk("rst_locked", 32'(a_locked), 32'h0);
      chk("rst_mem_we", 32'(a_mem_we), 32'h0);
      chk("rst_mem_addr", 32'(a_mem_addr), 32'h0);
      chk("rst_conflict", a_cnt, 32'h0);
      next_cycle();

      // Round-robin reads on dut_a.
      reset_all();
      addr = {17'h33, 17'h22, 17'h11};
      req  = 3'b111;
      prev = '0;
      for (int t = 0; t < 7; t++) begin
         if (t == 6) req = '0;
         settle();
         if (t < 6) chk("rr_gnt", 32'(a_gnt), 32'(rr_gnt[t]));
         chk("rr_rvalid", 32'(a_rvalid), 32'(prev));
         if (t > 0) chk("rr_rdata", a_rdata, rr_data[t-1]);
         prev = (t < 6) ? rr_gnt[t] : 3'b000;
         next_cycle();
      end

      // Locked burst on dut_b (MAX_LOCK=64).
      reset_all();
      for (int t = 0; t < 6; t++) begin
         req  = lk_req[t];
         lock = lk_lock[t];
         settle();
         chk("lock_gnt", 32'(b_gnt), 32'(lk_gnt[t]));
         chk("lock_locked", 32'(b_locked), 32'(lk_lkd[t]));
         next_cycle();
      end

      // Forced release at MAX_LOCK=4 on dut_a.
      reset_all();
      req  = 3'b101;
      lock = 3'b001;
      for (int t = 0; t < 6; t++) begin
         settle();
         chk("maxlock_gnt", 32'(a_gnt), 32'(ml_gnt[t]));
         chk("maxlock_locked", 32'(a_locked), 32'(ml_lkd[t]));
         next_cycle();
      end

      // Write then read-back on dut_a.
      reset_all();
      addr  = {17'h00010, 17'h0, 17'h00010};
      wdata = {32'hDEAD_BEEF, 64'h0};
      req   = 3'b100;
      we    = 3'b100;
      settle();
      chk("wr_gnt", 32'(a_gnt), 32'h4);
      chk("wr_mem_we", 32'(a_mem_we), 32'h1);
      chk("wr_mem_addr", 32'(a_mem_addr), 32'h10);
      chk("wr_mem_din", a_mem_din, 32'hDEAD_BEEF);
      next_cycle();
      req = 3'b001;
      we  = 3'b000;
      settle();
      chk("rd_gnt", 32'(a_gnt), 32'h1);
      chk("rd_mem_we", 32'(a_mem_we), 32'h0);
      chk("wr_no_rvalid", 32'(a_rvalid), 32'h0);
      next_cycle();
      req = '0;
      settle();
      chk("rd_rvalid", 32'(a_rvalid), 32'h1);
      chk("rd_rdata", a_rdata, 32'hDEAD_BEEF);
      chk("idle_gnt", 32'(a_gnt), 32'h0);
      chk("idle_addr_hold", 32'(a_mem_addr), 32'h10);
      next_cycle();
      settle();
      chk("rd_rvalid_once", 32'(a_rvalid), 32'h0);
      next_cycle();

      // Reset with a read in flight on dut_b (READ_LATENCY=3).
      reset_all();
      addr = {17'h0, 17'h5, 17'h0};
      req  = 3'b010;
      lock = 3'b010;
      settle();
      chk("mid_gnt", 32'(b_gnt), 32'h2);
      next_cycle();
      rst = 1'b1;
      settle();
      chk("mid_gnt_in_rst", 32'(b_gnt), 32'h0);
      chk("mid_we_in_rst", 32'(b_mem_we), 32'h0);
      next_cycle();
      rst  = 1'b0;
      req  = '0;
      lock = '0;
      for (int t = 0; t < 4; t++) begin
         settle();
         chk("mid_no_rvalid", 32'(b_rvalid), 32'h0);
         chk("mid_locked", 32'(b_locked), 32'h0);
         next_cycle();
      end
      req = 3'b110;
      settle();
      chk("mid_post_gnt", 32'(b_gnt), 32'h2);
      next_cycle();

      // Conflict statistics.
      reset_all();
      settle();
      chk("stat_zero", a_cnt, 32'h0);
      next_cycle();
      req = 3'b101;
      for (int t = 0; t < 10; t++) next_cycle();
      req = 3'b001;
      settle();
      chk("stat_mid", a_cnt, ExpConflicts);
      for (int t = 0; t < 5; t++) next_cycle();
      req = '0;
      settle();
      chk("stat_a", a_cnt, ExpConflicts);
      chk("stat_b", b_cnt, ExpConflicts);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
